perips_irq_gateway: RTL and testbench

//  Interrupt gateway/arbiter downstream of the peripheral subsystem. Consumes the 12 level IRQ lines
//  (UART x3, GPIO x4, I2C x3, SPI x2, bit order = perips_core_ei_o) and latches them as pending.

---
 rtl/perips_pkg.sv | 16 +
 rtl/perips_irq_arb.sv | 32 +++
 rtl/perips_irq_gateway.sv | 160 ++++++++++++++++
 tb/tb_perips_irq_gateway.sv | 254 +++++++++++++++++++++++++
 4 files changed

// File: rtl/perips_pkg.sv
// Shared definitions for the peripheral interrupt gateway: register offsets and ID/priority types.
package perips_pkg;

   localparam int unsigned IRQ_PRIO_W = 3;
   localparam int unsigned IRQ_ID_W   = 5;

   localparam logic [6:0] IRQ_PENDING_OFS = 7'h00;
   localparam logic [6:0] IRQ_ENABLE_OFS  = 7'h04;
   localparam logic [6:0] IRQ_THRESH_OFS  = 7'h08;
   localparam logic [6:0] IRQ_CLAIM_OFS   = 7'h0C;
   localparam logic [6:0] IRQ_PRIO_BASE   = 7'h40;

   typedef logic [IRQ_ID_W-1:0]   irq_id_t;
   typedef logic [IRQ_PRIO_W-1:0] irq_prio_t;

endpackage

// File: rtl/perips_irq_arb.sv
// Combinational priority selector: highest enabled priority above threshold wins, ties to lowest index.
module perips_irq_arb
   import perips_pkg::*;
#(
   parameter int unsigned NUM_SRC = 12,
   parameter int unsigned PRIO_W  = IRQ_PRIO_W
) (
   input  logic [NUM_SRC-1:0] pending_i,
   input  logic [NUM_SRC-1:0] enable_i,
   input  logic [PRIO_W-1:0]  prio_i [NUM_SRC],
   input  logic [PRIO_W-1:0]  thresh_i,
   output irq_id_t            best_id_c_o,
   output logic               valid_c_o
);

   logic [PRIO_W-1:0] best_prio;

   // Ascending scan with strict compare keeps the lowest index on equal priority.
   always_comb begin
      best_prio   = '0;
      best_id_c_o = '0;
      for (int unsigned i = 0; i < NUM_SRC; i++) begin
         if (pending_i[i] && enable_i[i] && (prio_i[i] > thresh_i) && (prio_i[i] > best_prio)) begin
            best_prio   = prio_i[i];
            best_id_c_o = irq_id_t'(i + 1);
         end
      end
   end

   assign valid_c_o = (best_id_c_o != '0);

endmodule

// File: rtl/perips_irq_gateway.sv
// Interrupt gateway with Wishbone claim/complete port driving one core external interrupt.
// Optional PERIPS_IRQ_SYNC_EN adds a 2-flop synchronizer on every source line.
module perips_irq_gateway
   import perips_pkg::*;
#(
   parameter int unsigned NUM_SRC      = 12,
   parameter int unsigned PRIO_W       = IRQ_PRIO_W,
   parameter int unsigned WB_AD_WIDTH  = 32,
   parameter int unsigned WB_DAT_WIDTH = 32
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic [NUM_SRC-1:0]        src_irq_i,
   input  logic                      wbm_irq_cyc_i,
   input  logic                      wbm_irq_stb_i,
   input  logic                      wbm_irq_we_i,
   input  logic [WB_AD_WIDTH-1:0]    wbm_irq_addr_i,
   input  logic [WB_DAT_WIDTH-1:0]   wbm_irq_wdata_i,
   input  logic [WB_DAT_WIDTH/8-1:0] wbm_irq_sel_i,
   output logic [WB_DAT_WIDTH-1:0]   irq_wbm_rdata_o,
   output logic                      irq_wbm_ack_o,
   output logic                      core_ext_irq_o
);

   localparam int unsigned WORD_W = 5;
   localparam logic [WORD_W-1:0] W_PEND = IRQ_PENDING_OFS[6:2];
   localparam logic [WORD_W-1:0] W_EN   = IRQ_ENABLE_OFS[6:2];
   localparam logic [WORD_W-1:0] W_THR  = IRQ_THRESH_OFS[6:2];
   localparam logic [WORD_W-1:0] W_CLM  = IRQ_CLAIM_OFS[6:2];
   localparam logic [WORD_W-1:0] W_PRIO = IRQ_PRIO_BASE[6:2];

   logic [NUM_SRC-1:0] src_gw;

`ifdef PERIPS_IRQ_SYNC_EN
   logic [NUM_SRC-1:0] sync1_q, sync2_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         sync1_q <= '0;
         sync2_q <= '0;
      end else begin
         sync1_q <= src_irq_i;
         sync2_q <= sync1_q;
      end
   end

   assign src_gw = sync2_q;
`else
   assign src_gw = src_irq_i;
`endif

   logic [NUM_SRC-1:0]      pending_q, pending_d;
   logic [NUM_SRC-1:0]      in_flight_q, in_flight_d;
   logic [NUM_SRC-1:0]      enable_q, enable_d;
   logic [PRIO_W-1:0]       thresh_q, thresh_d;
   logic [PRIO_W-1:0]       prio_q [NUM_SRC];
   logic [PRIO_W-1:0]       prio_d [NUM_SRC];
   logic                    ack_q, ack_d;
   logic [WB_DAT_WIDTH-1:0] rdata_q, rdata_d;
   logic                    irq_q, irq_d;

   irq_id_t                 best_id;
   logic                    best_vld;
   logic                    req;
   logic [WORD_W-1:0]       word;
   logic                    unused_ok;

   perips_irq_arb #(
      .NUM_SRC (NUM_SRC),
      .PRIO_W  (PRIO_W)
   ) u_arb (
      .pending_i   (pending_q),
      .enable_i    (enable_q),
      .prio_i      (prio_q),
      .thresh_i    (thresh_q),
      .best_id_c_o (best_id),
      .valid_c_o   (best_vld)
   );

   assign req       = wbm_irq_cyc_i & wbm_irq_stb_i & ~ack_q;
   assign word      = wbm_irq_addr_i[6:2];
   assign unused_ok = ^{wbm_irq_addr_i[WB_AD_WIDTH-1:7], wbm_irq_addr_i[1:0], wbm_irq_sel_i};

   // Gateway, register file and claim/complete; the claim clear is applied after the gateway set.
   always_comb begin
      pending_d   = pending_q | (src_gw & ~in_flight_q);
      in_flight_d = in_flight_q;
      enable_d    = enable_q;
      thresh_d    = thresh_q;
      prio_d      = prio_q;
      ack_d       = req;
      rdata_d     = '0;
      irq_d       = best_vld;
      if (req) begin
         if (wbm_irq_we_i) begin
            case (word)
               W_EN:  enable_d = wbm_irq_wdata_i[NUM_SRC-1:0];
               W_THR: thresh_d = wbm_irq_wdata_i[PRIO_W-1:0];
               W_CLM: begin
                  for (int unsigned i = 0; i < NUM_SRC; i++) begin
                     if (wbm_irq_wdata_i == WB_DAT_WIDTH'(i + 1)) in_flight_d[i] = 1'b0;
                  end
               end
               default: begin
                  for (int unsigned i = 0; i < NUM_SRC; i++) begin
                     if (word == W_PRIO + WORD_W'(i)) prio_d[i] = wbm_irq_wdata_i[PRIO_W-1:0];
                  end
               end
            endcase
         end else begin
            case (word)
               W_PEND: rdata_d = WB_DAT_WIDTH'(pending_q);
               W_EN:   rdata_d = WB_DAT_WIDTH'(enable_q);
               W_THR:  rdata_d = WB_DAT_WIDTH'(thresh_q);
               W_CLM: begin
                  rdata_d = WB_DAT_WIDTH'(best_id);
                  for (int unsigned i = 0; i < NUM_SRC; i++) begin
                     if (best_id == irq_id_t'(i + 1)) begin
                        pending_d[i]   = 1'b0;
                        in_flight_d[i] = 1'b1;
                     end
                  end
               end
               default: begin
                  for (int unsigned i = 0; i < NUM_SRC; i++) begin
                     if (word == W_PRIO + WORD_W'(i)) rdata_d = WB_DAT_WIDTH'(prio_q[i]);
                  end
               end
            endcase
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         pending_q   <= '0;
         in_flight_q <= '0;
         enable_q    <= '0;
         thresh_q    <= '0;
         ack_q       <= 1'b0;
         rdata_q     <= '0;
         irq_q       <= 1'b0;
         for (int unsigned i = 0; i < NUM_SRC; i++) prio_q[i] <= '0;
      end else begin
         pending_q   <= pending_d;
         in_flight_q <= in_flight_d;
         enable_q    <= enable_d;
         thresh_q    <= thresh_d;
         ack_q       <= ack_d;
         rdata_q     <= rdata_d;
         irq_q       <= irq_d;
         for (int unsigned i = 0; i < NUM_SRC; i++) prio_q[i] <= prio_d[i];
      end
   end

   assign irq_wbm_rdata_o = rdata_q;
   assign irq_wbm_ack_o   = ack_q;
   assign core_ext_irq_o  = irq_q;

endmodule

// File: tb/tb_perips_irq_gateway.sv
// Randomized scoreboard bench for perips_irq_gateway against a spec-level gateway model.
module tb_perips_irq_gateway;

   localparam int NS = 12;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic [NS-1:0] src = '0;
   logic          cyc = 1'b0, stb = 1'b0, we = 1'b0;
   logic [31:0]   addr = '0, wdata = '0;
   logic [3:0]    sel = 4'hF;
   logic [31:0]   rdata;
   logic          ack, irq;

   perips_irq_gateway dut (
      .clk             (clk),
      .rst             (rst),
      .src_irq_i       (src),
      .wbm_irq_cyc_i   (cyc),
      .wbm_irq_stb_i   (stb),
      .wbm_irq_we_i    (we),
      .wbm_irq_addr_i  (addr),
      .wbm_irq_wdata_i (wdata),
      .wbm_irq_sel_i   (sel),
      .irq_wbm_rdata_o (rdata),
      .irq_wbm_ack_o   (ack),
      .core_ext_irq_o  (irq)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic [31:0] data;
      logic        chk;
   } exp_t;

   exp_t      exp_q[$];
   int        errors = 0, checks = 0, ack_cnt = 0;
   bit        mon_en = 0;

   // Model state as seen after each rising edge
   bit [NS-1:0] m_pend, m_inf, m_en, m_s1, m_s2;
   int          m_prio [NS];
   int          m_thr;
   bit          m_ack, m_irq;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
      end
   endtask

   function automatic bit cand(input int i);
      return m_pend[i] && m_en[i] && (m_prio[i] > m_thr);
   endfunction

   // Best ID: find top priority among candidates, then first source holding it
   function automatic int m_best();
      int top = 0;
      for (int i = 0; i < NS; i++) if (cand(i) && m_prio[i] > top) top = m_prio[i];
      if (top == 0) return 0;
      for (int i = 0; i < NS; i++) if (cand(i) && m_prio[i] == top) return i + 1;
      return 0;
   endfunction

   task automatic tick();
      bit [NS-1:0] np, ni, ne, ns1, ns2, se;
      int          npr [NS];
      int          nt, b, w, id;
      bit          nack, nirq, push, pchk;
      logic [31:0] rv;
      np = m_pend; ni = m_inf; ne = m_en; nt = m_thr; npr = m_prio;
      ns1 = '0; ns2 = '0; nack = 0; nirq = 0; push = 0; pchk = 0; rv = '0;
      if (rst) begin
         np = '0; ni = '0; ne = '0; nt = 0;
         for (int i = 0; i < NS; i++) npr[i] = 0;
      end else begin
`ifdef PERIPS_IRQ_SYNC_EN
         se = m_s2; ns2 = m_s1; ns1 = src;
`else
         se = src;
`endif
         b    = m_best();
         nirq = (b != 0);
         for (int i = 0; i < NS; i++) if (se[i] && !m_inf[i]) np[i] = 1'b1;
         nack = cyc && stb && !m_ack;
         if (nack) begin
            w    = int'(addr[6:2]);
            push = 1;
            if (we) begin
               case (w)
                  1: ne = wdata[NS-1:0];
                  2: nt = int'(wdata[2:0]);
                  3: if (wdata >= 32'd1 && wdata <= 32'(NS)) begin
                        id = int'(wdata);
                        ni[id-1] = 1'b0;
                     end
                  default: if (w >= 16 && w < 16 + NS) npr[w-16] = int'(wdata[2:0]);
               endcase
            end else begin
               pchk = 1;
               case (w)
                  0: rv = 32'(m_pend);
                  1: rv = 32'(m_en);
                  2: rv = 32'(m_thr);
                  3: begin
                     rv = 32'(b);
                     if (b != 0) begin
                        np[b-1] = 1'b0;
                        ni[b-1] = 1'b1;
                     end
                  end
                  default: rv = (w >= 16 && w < 16 + NS) ? 32'(m_prio[w-16]) : 32'd0;
               endcase
            end
         end
      end
      @(posedge clk);
      #1;
      m_pend = np; m_inf = ni; m_en = ne; m_thr = nt; m_prio = npr;
      m_s1 = ns1; m_s2 = ns2; m_ack = nack; m_irq = nirq;
      if (push) exp_q.push_back('{data: rv, chk: pchk});
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) tick();
   endtask

   task automatic wb(input bit w_en, input logic [31:0] a, input logic [31:0] d);
      cyc = 1; stb = 1; we = w_en; addr = a; wdata = d;
      tick();
      cyc = 0; stb = 0; we = 0;
      tick();
   endtask

   task automatic rd(input logic [31:0] a);
      wb(0, a, 32'd0);
   endtask

   task automatic wr(input logic [31:0] a, input logic [31:0] d);
      wb(1, a, d);
   endtask

   task automatic read_all();
      rd(32'h00); rd(32'h04); rd(32'h08); rd(32'h0C);
      for (int i = 0; i < NS; i++) rd(32'h40 + 32'(4 * i));
   endtask

   // Monitor: compares ack/irq against the model each cycle and pops the scoreboard on every ack
   always @(negedge clk) begin
      exp_t e;
      if (mon_en) begin
         chk("ack", 32'(ack), 32'(m_ack));
         chk("core_ext_irq", 32'(irq), 32'(m_irq));
         if (ack) begin
            ack_cnt++;
            if (exp_q.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL unexpected_ack: ack seen with empty scoreboard at %0t", $time);
            end else begin
               e = exp_q.pop_front();
               if (e.chk) chk("rdata", rdata, e.data);
            end
         end else begin
            chk("rdata_idle", rdata, 32'd0);
         end
      end
   end

   initial begin
      int a0;
      // 1: reset state and unmapped reads
      tick();
      mon_en = 1;
      tick();
      rst = 0;
      read_all();
      rd(32'h10); rd(32'h3C); rd(32'h70); rd(32'h7C);

      // 2: single source, claim and complete with line low
      wr(32'h4C, 5); wr(32'h04, 32'h008); wr(32'h08, 0);
      src[3] = 1; tick(); src[3] = 0;
      idle(4);
      rd(32'h0C); idle(2); rd(32'h00);
      wr(32'h0C, 4); idle(3);

      // 3: tie on priority goes to lower index, then lower priority
      wr(32'h44, 4); wr(32'h58, 4); wr(32'h64, 2); wr(32'h04, 32'h242);
      src = 12'h242; idle(4); src = '0;
      rd(32'h0C); wr(32'h0C, 2); rd(32'h0C); wr(32'h0C, 7); rd(32'h0C); wr(32'h0C, 10);
      idle(2);

      // 4: threshold gating
      wr(32'h04, 32'h001); wr(32'h40, 4); wr(32'h08, 4);
      src[0] = 1; idle(4);
      wr(32'h08, 3); idle(3);
      rd(32'h0C); src[0] = 0; wr(32'h0C, 1); idle(2);

      // 5: held line re-pends after complete; bogus completes ignored
      wr(32'h48, 6); wr(32'h04, 32'h004);
      src[2] = 1; idle(4);
      rd(32'h0C); wr(32'h0C, 3); idle(3);
      rd(32'h0C); wr(32'h0C, 0); wr(32'h0C, 13); wr(32'h0C, 5); rd(32'h00);
      src[2] = 0; wr(32'h0C, 3); idle(3);

      // 6: held strobe yields one ack per two cycles, then reset mid-transaction
      wr(32'h04, 32'hFFF); wr(32'h50, 3); wr(32'h54, 6); wr(32'h5C, 1);
      src = 12'h0F0; idle(4);
      a0 = ack_cnt;
      cyc = 1; stb = 1; we = 0; addr = 32'h0C;
      idle(4);
      cyc = 0; stb = 0;
      tick();
      chk("held_stb_acks", 32'(ack_cnt - a0), 32'd2);
      cyc = 1; stb = 1; addr = 32'h0C; rst = 1;
      tick();
      rst = 0; cyc = 0; stb = 0; src = '0;
      tick();
      read_all();

      // Random phase
      for (int i = 0; i < NS; i++) wr(32'h40 + 32'(4 * i), 32'($urandom_range(0, 7)));
      wr(32'h04, 32'($urandom_range(0, 4095)));
      for (int n = 0; n < 700; n++) begin
         if ($urandom_range(0, 3) == 0) src = NS'($urandom);
         case ($urandom_range(0, 9))
            0, 1: idle(1);
            2:    rd(32'($urandom_range(0, 31)) << 2);
            3, 4: rd(32'h0C);
            5, 6: wr(32'h0C, 32'($urandom_range(0, 15)));
            7:    wr(32'h04, 32'($urandom_range(0, 4095)));
            8:    wr(32'h08, 32'($urandom_range(0, 3)));
            default: begin
               if ($urandom_range(0, 1) == 0) wr(32'h40 + 32'(4 * $urandom_range(0, NS - 1)), 32'($urandom_range(0, 7)));
               else begin
                  cyc = 0; stb = 1; addr = 32'h0C; tick(); stb = 0; tick();
               end
            end
         endcase
      end
      idle(3);
      if (exp_q.size() != 0) begin
         checks++;
         errors++;
         $display("FAIL missing_acks: %0d expected responses never seen", exp_q.size());
      end
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
